// File: rtl/shift_dir_pkg.sv
// Shared bit-order type for the serializer/deserializer pair.
//   MSB_FIRST : word bit N-1 travels first on the serial line.
//   LSB_FIRST : word bit 0 travels first on the serial line.
package shift_dir_pkg;

   typedef enum logic {
      MSB_FIRST = 1'b0,
      LSB_FIRST = 1'b1
   } shift_direction_t_;

endpackage

// File: rtl/serial_to_parallel_converter.sv
// Deserializer: assembles a framed serial bitstream into N-bit words and presents each
// completed word on a valid/ready handshake. Bits that arrive while a finished word is
// still waiting for the consumer are dropped and recorded in a sticky overrun flag.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   i_en       serial bit qualifier
//   i_start    with i_en, marks the current bit as bit 0 of a new word
//   direction  bit order, latched on frame-start cycles only
//   i_serial   serial data bit
//   o_data     assembled word, held until the next word completes
//   o_valid    word available
//   i_ready    consumer accepts the word when o_valid & i_ready
//   o_busy     frame in progress
//   o_overrun  sticky: a qualified bit was dropped while a word was pending
module serial_to_parallel_converter
   import shift_dir_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic              i_start,
   input  shift_direction_t_ direction,
   input  logic              i_serial,
   output logic [N-1:0]      o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_overrun
);

   localparam int unsigned CntW = $clog2(N + 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      shift_q, shift_d;
   logic [CntW-1:0]   count_q, count_d;
   shift_direction_t_ dir_q, dir_d;
   logic [N-1:0]      data_q, data_d;
   logic              overrun_q, overrun_d;

   logic [N-1:0]      shift_cont;   // current frame extended by the incoming bit
   logic [N-1:0]      shift_first;  // fresh frame holding only the incoming bit
   logic              frame_start;

   function automatic logic [N-1:0] shift_in(input logic [N-1:0] s, input logic b,
                                             input shift_direction_t_ d);
      if (d == MSB_FIRST) begin
         return {s[N-2:0], b};
      end
      return {b, s[N-1:1]};
   endfunction

   assign shift_cont  = shift_in(shift_q, i_serial, dir_q);
   assign shift_first = shift_in('0, i_serial, direction);
   assign frame_start = i_en & i_start;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      count_d   = count_q;
      dir_d     = dir_q;
      data_d    = data_q;
      overrun_d = overrun_q;

      unique case (state_q)
         StIdle: begin
            // Qualified bits without a start are noise between frames.
            if (frame_start) begin
               dir_d   = direction;
               shift_d = shift_first;
               count_d = CntW'(1);
               state_d = StShift;
            end
         end

         StShift: begin
            if (frame_start) begin
               // Resync: drop the partial word, this bit begins a new one.
               dir_d   = direction;
               shift_d = shift_first;
               count_d = CntW'(1);
            end else if (i_en) begin
               shift_d = shift_cont;
               if (count_q == CntW'(N - 1)) begin
                  data_d  = shift_cont;
                  count_d = '0;
                  state_d = StDone;
               end else begin
                  count_d = count_q + CntW'(1);
               end
            end
         end

         StDone: begin
            if (i_ready) begin
               if (frame_start) begin
                  dir_d   = direction;
                  shift_d = shift_first;
                  count_d = CntW'(1);
                  state_d = StShift;
               end else begin
                  state_d = StIdle;
               end
            end
            // Only a start coinciding with the handshake is consumed; any other
            // qualified bit has nowhere to go.
            if (i_en && !(i_ready && i_start)) begin
               overrun_d = 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         count_q   <= '0;
         dir_q     <= MSB_FIRST;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         count_q   <= count_d;
         dir_q     <= dir_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_data    = data_q;
   assign o_valid   = (state_q == StDone);
   assign o_busy    = (state_q == StShift);
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Self-checking bench for serial_to_parallel_converter (N=4). Expected words are pushed
// to a scoreboard queue when their frame is driven and popped when o_valid is seen.
module tb_serial_to_parallel_converter;
   import shift_dir_pkg::*;

   localparam int unsigned N = 4;

   logic              clk;
   logic              rst;
   logic              i_en;
   logic              i_start;
   shift_direction_t_ direction;
   logic              i_serial;
   logic [N-1:0]      o_data;
   logic              o_valid;
   logic              i_ready;
   logic              o_busy;
   logic              o_overrun;

   int unsigned checks;
   int unsigned errors;
   logic [N-1:0] exp_q[$];

   serial_to_parallel_converter #(
      .N(N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_en     (i_en),
      .i_start  (i_start),
      .direction(direction),
      .i_serial (i_serial),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_busy   (o_busy),
      .o_overrun(o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of serial stimulus; outputs are sampled 1 time unit after the edge.
   task automatic drive(input logic en, input logic st, input logic b);
      i_en     = en;
      i_start  = st;
      i_serial = b;
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for o_valid without consuming it; ok=0 on timeout.
   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (o_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         drive(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
      checks++;
      if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", o_overrun); end
      checks++;
      if (o_data !== 4'b0000) begin errors++; $display("FAIL reset_data got %b want 0000", o_data); end
   endtask

   task automatic test_msb_first;
      logic [N-1:0] exp;
      i_ready   = 1'b1;
      direction = MSB_FIRST;
      exp_q.push_back(4'b1011);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL msb_early_valid got %b want 0", o_valid); end
      drive(1'b1, 1'b0, 1'b1);
      checks++;
      if (o_valid !== 1'b1) begin errors++; $display("FAIL msb_valid_latency got %b want 1", o_valid); end
      exp = exp_q.pop_front();
      checks++;
      if (o_data !== exp) begin errors++; $display("FAIL msb_data got %b want %b", o_data, exp); end
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL msb_valid_one_cycle got %b want 0", o_valid); end
      checks++;
      if (o_data !== exp) begin errors++; $display("FAIL msb_data_held got %b want %b", o_data, exp); end
   endtask

   task automatic test_lsb_first;
      logic [N-1:0] exp;
      bit ok;
      i_ready   = 1'b1;
      direction = LSB_FIRST;
      exp_q.push_back(4'b1101);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lsb_timeout got no valid want valid"); end
      else begin
         exp = exp_q.pop_front();
         checks++;
         if (o_data !== exp) begin errors++; $display("FAIL lsb_data got %b want %b", o_data, exp); end
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   // Words serialized as the partner serializer would; the next frame starts on the
   // handshake cycle of the previous one.
   task automatic test_loopback;
      logic [N-1:0] w;
      logic [N-1:0] exp;
      shift_direction_t_ d;
      i_ready = 1'b1;
      for (int di = 0; di < 2; di++) begin
         d = (di == 0) ? MSB_FIRST : LSB_FIRST;
         for (int wi = 0; wi < 16; wi++) begin
            w = wi[N-1:0];
            exp_q.push_back(w);
            for (int k = 0; k < N; k++) begin
               direction = (k == 0) ? d : ((d == MSB_FIRST) ? LSB_FIRST : MSB_FIRST);
               drive(1'b1, (k == 0), (d == MSB_FIRST) ? w[N-1-k] : w[k]);
            end
            checks++;
            if (o_valid !== 1'b1 || exp_q.size() == 0) begin
               errors++;
               $display("FAIL loopback_valid dir=%0d word=%b got valid=%b want 1", di, w, o_valid);
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
               exp = exp_q.pop_front();
               checks++;
               if (o_data !== exp) begin
                  errors++;
                  $display("FAIL loopback_data dir=%0d got %b want %b", di, o_data, exp);
               end
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (o_overrun !== 1'b0) begin errors++; $display("FAIL loopback_overrun got %b want 0", o_overrun); end
   endtask

   task automatic test_stall;
      logic [N-1:0] exp;
      i_ready   = 1'b1;
      direction = MSB_FIRST;
      exp_q.push_back(4'b1011);
      drive(1'b1, 1'b1, 1'b1);
      direction = LSB_FIRST;  // must be ignored mid-frame
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1);
         checks++;
         if (o_busy !== 1'b1) begin errors++; $display("FAIL stall_busy cycle=%0d got %b want 1", i, o_busy); end
      end
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      checks++;
      if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", o_valid); end
      exp = exp_q.pop_front();
      checks++;
      if (o_data !== exp) begin errors++; $display("FAIL stall_data got %b want %b", o_data, exp); end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_resync;
      logic [N-1:0] exp;
      bit ok;
      i_ready   = 1'b1;
      direction = MSB_FIRST;
      exp_q.push_back(4'b0101);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL resync_timeout got no valid want valid"); end
      else begin
         exp = exp_q.pop_front();
         checks++;
         if (o_data !== exp) begin errors++; $display("FAIL resync_data got %b want %b", o_data, exp); end
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (o_overrun !== 1'b0) begin errors++; $display("FAIL resync_overrun got %b want 0", o_overrun); end
   endtask

   task automatic test_back_to_back;
      logic [N-1:0] exp;
      i_ready   = 1'b1;
      direction = MSB_FIRST;
      exp_q.push_back(4'b1001);
      exp_q.push_back(4'b0110);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp) begin
         errors++;
         $display("FAIL b2b_first got valid=%b data=%b want valid=1 data=%b", o_valid, o_data, exp);
      end
      drive(1'b1, 1'b1, 1'b0);  // start of second frame on the handshake cycle
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_handoff got valid=%b busy=%b want valid=0 busy=1", o_valid, o_busy);
      end
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp) begin
         errors++;
         $display("FAIL b2b_second got valid=%b data=%b want valid=1 data=%b", o_valid, o_data, exp);
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (o_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", o_overrun); end
   endtask

   task automatic test_backpressure;
      logic [N-1:0] exp;
      i_ready   = 1'b0;
      direction = MSB_FIRST;
      exp_q.push_back(4'b1011);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      exp = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (o_valid !== 1'b1 || o_data !== exp) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d got valid=%b data=%b want valid=1 data=%b",
                     i, o_valid, o_data, exp);
         end
         drive((i < 2), 1'b0, 1'b1);
      end
      checks++;
      if (o_overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", o_overrun); end
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp) begin
         errors++;
         $display("FAIL bp_still_valid got valid=%b data=%b want valid=1 data=%b", o_valid, o_data, exp);
      end
      i_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", o_valid); end
      checks++;
      if (o_overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky_overrun got %b want 1", o_overrun); end
   endtask

   task automatic test_reset_midframe;
      logic [N-1:0] exp;
      bit ok;
      i_ready   = 1'b1;
      direction = MSB_FIRST;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1);  // reset must win over a start
      rst = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_overrun !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got busy=%b valid=%b overrun=%b want 0 0 0", o_busy, o_valid, o_overrun);
      end
      checks++;
      if (o_data !== 4'b0000) begin errors++; $display("FAIL rst_mid_data got %b want 0000", o_data); end
      exp_q.push_back(4'b0110);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_mid_timeout got no valid want valid"); end
      else begin
         exp = exp_q.pop_front();
         checks++;
         if (o_data !== exp) begin errors++; $display("FAIL rst_mid_data_after got %b want %b", o_data, exp); end
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      i_en      = 1'b0;
      i_start   = 1'b0;
      i_serial  = 1'b0;
      i_ready   = 1'b0;
      direction = MSB_FIRST;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_loopback();
      test_stall();
      test_resync();
      test_back_to_back();
      test_backpressure();
      test_reset_midframe();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_to_parallel_converter.md
Name: serial_to_parallel_converter

Overview:
- Downstream partner of parallel_to_serial_converter: deserializes a framed serial bitstream back into N-bit words.
- Supports both shift orders, using the shared shift_direction_t_ enum (MSB_FIRST, LSB_FIRST).
- Each assembled word is presented on a valid/ready output handshake.
- Flags any bits lost while a completed word waits for the consumer.

Parameters:
- N, 4, word width in bits; N >= 2 required.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- i_en  input  1  serial bit qualifier; i_serial is sampled only when i_en=1.
- i_start  input  1  frame start; meaningful only with i_en=1; marks the current bit as bit 0 of a new word.
- direction  input  shift_direction_t_  bit order; latched on a frame-start cycle.
- i_serial  input  1  serial data bit.
- o_data  output  N  assembled word; stable while o_valid=1.
- o_valid  output  1  word available.
- i_ready  input  1  consumer accepts the word when o_valid & i_ready.
- o_busy  output  1  frame in progress (state SHIFT).
- o_overrun  output  1  sticky: a qualified bit was dropped.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; shift reg, bit count, o_data = 0.
  - o_valid=0, o_busy=0, o_overrun=0.
  - Any partial frame or pending word is discarded.
  - rst has priority over every other input.
- Registered state: state {IDLE, SHIFT, DONE}, shift reg s[N-1:0], count of $clog2(N+1) bits, latched dir.
- Shift rule for one qualified bit b:
  - MSB_FIRST: s <= {s[N-2:0], b}.
  - LSB_FIRST: s <= {b, s[N-1:1]}.
  - After N bits, the first bit lands in o_data[N-1] for MSB_FIRST and in o_data[0] for LSB_FIRST.
  - So a word serialized by parallel_to_serial_converter with the same direction is reproduced exactly.
- IDLE:
  - i_en & i_start: dir<=direction; s cleared and shifted with the bit; count<=1; go SHIFT.
  - i_en without i_start: bit ignored, no flag.
- SHIFT:
  - o_busy=1.
  - i_en=0: hold; stalls of any length are allowed.
  - i_en & !i_start: shift bit; count++.
  - i_en & i_start: resync; discard the partial word; dir<=direction; this bit is the first bit; count<=1; no flag.
  - When the shifted bit is the Nth (count==N-1 before the shift): next cycle o_data<=new shift value, o_valid<=1, state DONE, count<=0.
  - Latency: o_valid rises on the posedge after the Nth bit is sampled.
- DONE:
  - o_valid=1; o_data held.
  - Handshake (i_ready=1): next cycle o_valid=0.
    - If i_en & i_start on the same cycle, start a new frame (SHIFT, count=1).
    - Otherwise go IDLE.
  - i_ready=0 and i_en=1: bit dropped, o_overrun<=1.
  - i_ready=1 and i_en & !i_start: bit dropped, o_overrun<=1.
- o_overrun clears only on rst.
- o_data keeps its last word after the handshake until overwritten by the next completed word.
- The direction input is ignored outside frame-start cycles.

Test Plan:
- N=4, MSB_FIRST: i_en=1 for 4 cycles, i_start on the first, bits 1,0,1,1; i_ready=1 -> o_valid high exactly one cycle, one cycle after the 4th bit, o_data=4'b1011.
- LSB_FIRST: bits 1,0,1,1 -> o_data=4'b1101. Loopback from parallel_to_serial_converter for all 16 words in both directions -> every word recovered.
- Stalls: bits 1,0 then i_en=0 for 3 cycles, then 1,1 -> o_data=4'b1011; o_busy=1 throughout the stall.
- Backpressure: i_ready=0 for 5 cycles after completion, 2 qualified bits arrive -> o_data stable, o_valid stays 1, o_overrun=1. Then i_ready=1 -> o_valid drops, o_overrun stays 1.
- Resync: i_start with 1,1 then i_start with 0,1,0,1 -> o_data=4'b0101. Separately, back-to-back frames with i_ready=1 and the new start on the handshake cycle -> both words delivered, no overrun.
- Reset mid-frame after 2 bits -> o_busy=0, o_valid=0, o_overrun=0. The next full frame 0,1,1,0 -> o_data=4'b0110.
